// File: rtl/dadda_divider16_pkg.sv
// Shared widths, FSM states and special quotient codes for the 32/16 signed divider.
package dadda_divider16_pkg;
    localparam int DW    = 16;
    localparam int CNT_W = 5;

    localparam logic [DW-1:0] QUOT_OVF = 16'h8000;
    localparam logic [DW-1:0] QUOT_DBZ = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        SIGN,
        DONE
    } state_t;
endpackage

// File: rtl/dadda_divider16_div_step.sv
// One unsigned restoring-division iteration: shift in a dividend bit, trial-subtract, select.
module div_step #(
    parameter int DW = dadda_divider16_pkg::DW
) (
    input  logic [DW:0]   rem_i,
    input  logic          bit_i,
    input  logic [DW-1:0] dvs_i,
    output logic [DW:0]   rem_o,
    output logic          qbit_o
);
    logic [DW+1:0] shifted;
    logic [DW:0]   diff;
    logic          borrow;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted[DW:0] - {1'b0, dvs_i};
        borrow  = shifted < {2'b00, dvs_i};
        rem_o   = borrow ? shifted[DW:0] : diff;
        qbit_o  = ~borrow;
    end
endmodule

// File: rtl/dadda_divider16.sv
// Signed 2*DW / DW divider, truncating toward zero; one restoring step per cycle plus a sign-fixup cycle.
module dadda_divider16 #(
    parameter int DW = dadda_divider16_pkg::DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [2*DW-1:0] dividend,
    input  logic signed [DW-1:0]   divisor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [DW-1:0]   quotient,
    output logic signed [DW-1:0]   remainder,
    output logic                   dbz,
    output logic                   ovf
);
    import dadda_divider16_pkg::*;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      quot_q, quot_d;
    logic [DW-1:0]      rmd_q, rmd_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    logic [DW:0]        rem_q, rem_d;
    logic [DW-1:0]      lo_q, lo_d;
    logic [DW-1:0]      dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;

    logic [2*DW-1:0]    dvd_abs;
    logic [DW-1:0]      dvs_abs;
    logic [DW:0]        step_rem;
    logic               step_qbit;
    logic [DW:0]        sat;

    function automatic logic [2*DW-1:0] abs_wide(input logic signed [2*DW-1:0] x);
        logic [2*DW-1:0] u;
        u = x;
        return x[2*DW-1] ? -u : u;
    endfunction

    function automatic logic [DW-1:0] abs_narrow(input logic signed [DW-1:0] x);
        logic [DW-1:0] u;
        u = x;
        return x[DW-1] ? -u : u;
    endfunction

    // Returns {overflow, signed quotient}; a negative result may reach -2^(DW-1), a positive one not.
    function automatic logic [DW:0] sat_quot(input logic [DW-1:0] mag, input logic neg);
        logic [DW-1:0] half;
        logic          ov;
        half = {1'b1, {(DW-1){1'b0}}};
        ov   = neg ? (mag > half) : (mag >= half);
        return {ov, neg ? -mag : mag};
    endfunction

    div_step #(.DW(DW)) u_step (
        .rem_i  (rem_q),
        .bit_i  (lo_q[DW-1]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dvd_abs = abs_wide(dividend);
        dvs_abs = abs_narrow(divisor);
        sat     = sat_quot(lo_q, qneg_q);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d  = dvs_abs;
                    rem_d  = {1'b0, dvd_abs[2*DW-1:DW]};
                    lo_d   = dvd_abs[DW-1:0];
                    qneg_d = dividend[2*DW-1] ^ divisor[DW-1];
                    rneg_d = dividend[2*DW-1];
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b0;
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        quot_d  = QUOT_DBZ;
                        rmd_d   = dividend[DW-1:0];
                        state_d = DONE;
                    end else if (dvd_abs[2*DW-1:DW] >= dvs_abs) begin
                        // Upper half already >= divisor: quotient cannot fit in DW bits.
                        ovf_d   = 1'b1;
                        quot_d  = QUOT_OVF;
                        rmd_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(DW);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = step_rem;
                lo_d  = {lo_q[DW-2:0], step_qbit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                if (sat[DW]) begin
                    ovf_d  = 1'b1;
                    quot_d = QUOT_OVF;
                    rmd_d  = '0;
                end else begin
                    quot_d = sat[DW-1:0];
                    rmd_d  = rneg_q ? -rem_q[DW-1:0] : rem_q[DW-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        lo_q   <= lo_d;
        dvs_q  <= dvs_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rmd_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;
endmodule

// File: doc/dadda_divider16.md
DADDA_DIVIDER16 -- requirements
Module: dadda_divider16

Interface
REQ-001 The block SHALL have parameter DW, default 16, giving the divisor/quotient/remainder width; the dividend is 2*DW bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, dividend/divisor valid.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept an operation.
REQ-006 The block SHALL have port dividend, input, 32, two's-complement dividend (product-width operand).
REQ-007 The block SHALL have port divisor, input, 16, two's-complement divisor.
REQ-008 The block SHALL have port out_valid, output, 1, result valid.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 The block SHALL have port quotient, output, 16, two's-complement quotient.
REQ-011 The block SHALL have port remainder, output, 16, two's-complement remainder.
REQ-012 The block SHALL have port dbz, output, 1, divide-by-zero flag, qualified by out_valid.
REQ-013 The block SHALL have port ovf, output, 1, quotient-overflow flag, qualified by out_valid.

Function
REQ-014 The block SHALL implement the inverse of the signed 16x16 product: signed dividend / signed divisor, truncating toward zero.
REQ-015 The remainder SHALL take the sign of the dividend and satisfy dividend = quotient*divisor + remainder with |remainder| < |divisor|.
REQ-016 The block SHALL use states IDLE, BUSY, SIGN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; an operation is accepted on an edge where in_valid and in_ready are both 1.
REQ-018 On accept, the block SHALL register the absolute values of both operands and the result signs (quotient: XOR of the operand signs; remainder: dividend sign).
REQ-019 On accept with divisor = 0, the block SHALL go to DONE with dbz=1, ovf=0, quotient=16'hFFFF, remainder=dividend[15:0].
REQ-020 On accept with |dividend|[31:16] >= |divisor|, divisor nonzero, the block SHALL go to DONE with ovf=1, dbz=0, quotient=16'h8000, remainder=16'h0000.
REQ-021 Otherwise, on accept, the block SHALL go to BUSY with a 5-bit iteration counter loaded to 16.
REQ-022 In BUSY, each cycle SHALL perform one unsigned restoring step: shift {partial remainder, dividend} left by 1, trial-subtract |divisor| from the 17-bit partial remainder, keep the difference if it is non-negative, shift in quotient bit = NOT borrow, and decrement the counter.
REQ-023 After the 16th step the block SHALL go to SIGN.
REQ-024 SIGN SHALL negate the quotient and remainder magnitudes per the registered signs.
REQ-025 SIGN SHALL set ovf=1 with quotient=16'h8000 and remainder=16'h0000 if the magnitude exceeds 32767 for a positive quotient or 32768 for a negative quotient.
REQ-026 SIGN SHALL then go to DONE.
REQ-027 Normal-path latency SHALL be fixed: out_valid rises 18 cycles after the accept edge; dbz/early-ovf latency SHALL be 1 cycle.
REQ-028 In DONE, out_valid SHALL be 1 and quotient, remainder, dbz and ovf SHALL hold stable until out_ready=1.
REQ-029 On a DONE edge with out_ready=1, the block SHALL return to IDLE; no new accept occurs on that same edge (minimum one IDLE cycle between operations).
REQ-030 in_valid and operand changes outside an accept edge SHALL be ignored.
REQ-031 out_ready outside DONE SHALL be ignored.

Reset
REQ-032 When rst=1 at a rising edge, the block SHALL enter IDLE regardless of state, abandoning any operation in flight.
REQ-033 Reset values SHALL be: in_ready=1, out_valid=0, quotient=0, remainder=0, dbz=0, ovf=0, counter=0.
REQ-034 A result SHALL NOT be produced for an operation interrupted by reset.

Structure
REQ-035 A shared package SHALL hold DW, the counter width, the state enum, and the constants QUOT_OVF=16'h8000 and QUOT_DBZ=16'hFFFF.
REQ-036 The block SHALL contain one combinational sub-module, div_step, performing the shift/trial-subtract/select for one iteration (inputs: partial remainder, next dividend bit, |divisor|; outputs: new partial remainder, quotient bit).
REQ-037 The FSM, counter and sign logic SHALL reside in the top module.

Verification
REQ-038 The bench SHALL cover: dividend=100, divisor=7 -> quotient=14, remainder=2, out_valid exactly 18 cycles after accept.
REQ-039 The bench SHALL cover: dividend=-100 (32'hFFFFFF9C), divisor=7 -> quotient=16'hFFF2, remainder=16'hFFFE, dbz=0, ovf=0.
REQ-040 The bench SHALL cover: dividend=32'hFFFF8000, divisor=1 -> quotient=16'h8000, ovf=0; and dividend=32'h00008000, divisor=1 -> ovf=1 from SIGN at 18 cycles.
REQ-041 The bench SHALL cover: dividend=32'h80000000, divisor=16'hFFFF -> ovf=1 one cycle after accept; dividend=5, divisor=0 -> dbz=1, quotient=16'hFFFF, remainder=16'h0005.
REQ-042 The bench SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-043 The bench SHALL cover: rst=1 in BUSY at step 8 -> next cycle in_ready=1, out_valid=0; a following operation 1000/-3 -> quotient=-333, remainder=1.
